// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: raw words, buffered fetch entries and FSM states.
package if_fetch_unit_pkg;

  typedef logic [31:0] raw_instr_t;
  typedef logic [31:0] uint32;

  localparam uint32 INSTR_BYTES = 32'd4;

  typedef struct packed {
    raw_instr_t instr;
    uint32      pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

  function automatic uint32 alignWord(input uint32 addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch stage and its neighbours: instruction memory, execute redirects, decode.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic       imem_req_valid;
  logic       imem_req_ready;
  uint32      imem_req_addr;
  logic       imem_rsp_valid;
  raw_instr_t imem_rsp_data;
  logic       redirect_valid;
  uint32      redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  raw_instr_t instr_data;
  uint32      instr_pc;
  logic       fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small circular FIFO of fetch entries; used both as the decode buffer and as the request address-tag queue.
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the slot first, so a full FIFO can still take a push in the same cycle.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);

  // Storage is cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (doPop) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: PC register, credit-limited memory requests, redirect flushing
// and a small buffer feeding decode over valid/ready.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter uint32       RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  if_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  fetch_state_e state_q, state_d;
  uint32        fetchPc_q, fetchPc_d;
  cnt_t         outstanding_q, outstanding_d;
  cnt_t         discard_q, discard_d;
  logic         misalign_q, misalign_d;

  fetch_entry_t bufHead;
  fetch_entry_t bufPushEntry;
  logic         bufEmpty;
  cnt_t         bufCount;
  logic         bufPush;
  logic         bufPop;

  fetch_entry_t tagHead;
  fetch_entry_t tagPushEntry;
  logic         unusedTagEmpty;
  cnt_t         unusedTagCount;
  raw_instr_t   unusedTagInstr;

  logic         credit;
  logic         reqFire;

  // Buffer slots are reserved at request time, so a returning response always has room.
  assign credit = ({1'b0, outstanding_q} + {1'b0, bufCount}) < SUM_W'(BUF_DEPTH);

  always_comb begin
    state_d       = state_q;
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    misalign_d    = misalign_q;

    bus.imem_req_valid = (state_q == RUN) && credit && !bus.redirect_valid;
    bus.instr_valid    = !bufEmpty && (state_q != FLUSH) && !bus.redirect_valid;
    reqFire            = bus.imem_req_valid && bus.imem_req_ready;
    bufPop             = bus.instr_valid && bus.instr_ready;
    bufPush            = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;

    outstanding_d = outstanding_q + cnt_t'(reqFire) - cnt_t'(bus.imem_rsp_valid);
    if (bus.imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    // Everything still in flight at a redirect is stale; the response landing this cycle is one of them.
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.redirect_valid) begin
          discard_d = outstanding_q - cnt_t'(bus.imem_rsp_valid);
          if (discard_d != '0) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (discard_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (bus.redirect_valid) begin
      fetchPc_d = alignWord(bus.redirect_pc);
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (reqFire) begin
      fetchPc_d = fetchPc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetchPc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      misalign_q    <= misalign_d;
    end
  end

  // Tags are popped by every response, dropped or not, so they stay aligned with memory order.
  assign tagPushEntry = '{instr: '0, pc: fetchPc_q};

  if_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (reqFire),
    .data_i  (tagPushEntry),
    .pop_i   (bus.imem_rsp_valid),
    .flush_i (1'b0),
    .head_o  (tagHead),
    .empty_o (unusedTagEmpty),
    .count_o (unusedTagCount)
  );

  assign unusedTagInstr = tagHead.instr;
  assign bufPushEntry   = '{instr: bus.imem_rsp_data, pc: tagHead.pc};

  if_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bufPush),
    .data_i  (bufPushEntry),
    .pop_i   (bufPop),
    .flush_i (bus.redirect_valid),
    .head_o  (bufHead),
    .empty_o (bufEmpty),
    .count_o (bufCount)
  );

  assign bus.imem_req_addr  = fetchPc_q;
  assign bus.instr_data     = bufHead.instr;
  assign bus.instr_pc       = bufHead.pc;
  assign bus.fetch_misalign = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: an in-order memory model with programmable latency plus a
// scoreboard of expected fetch addresses and decode-side instructions.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam uint32 RESET_PC = 32'h0000_0000;

  typedef struct {
    int    due;
    uint32 addr;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  pend_t pendQ[$];
  uint32 expInstrQ[$];
  uint32 expNextReq;
  uint32 firstInstrPc;
  uint32 firstReqAddr;
  uint32 heldData;
  int    cycleNum;
  int    lastDue;
  int    latency;
  int    reqCount;
  int    instrCount;
  int    total = 0;
  int    bad   = 0;
  logic  memReady;
  logic  decReady;

  function automatic uint32 memWord(input uint32 a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, redirect and readies at the falling edge,
  // then score whatever the DUT presents for the coming rising edge.
  task automatic applyStimulus(input logic redir, input uint32 rpc);
    pend_t p;
    uint32 pc;
    @(negedge clk);
    cycleNum++;
    bus.imem_req_ready = memReady;
    bus.instr_ready    = decReady;
    if (pendQ.size() != 0 && pendQ[0].due <= cycleNum) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memWord(pendQ[0].addr);
      void'(pendQ.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? rpc : $urandom;
    #1;
    if (redir) begin
      checkOutput("redir_kill_instr", 32'(bus.instr_valid), 32'd0);
      checkOutput("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
      expInstrQ.delete();
      expNextReq = {rpc[31:2], 2'b00};
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        checkOutput("req_addr", bus.imem_req_addr, expNextReq);
        if (reqCount == 0) firstReqAddr = bus.imem_req_addr;
        expInstrQ.push_back(expNextReq);
        p.due = cycleNum + latency;
        if (p.due <= lastDue) p.due = lastDue + 1;
        lastDue = p.due;
        p.addr  = bus.imem_req_addr;
        pendQ.push_back(p);
        expNextReq = expNextReq + 32'd4;
        reqCount++;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        checkOutput("sb_nonempty", 32'(expInstrQ.size() != 0), 32'd1);
        if (expInstrQ.size() != 0) begin
          pc = expInstrQ.pop_front();
          checkOutput("instr_pc", bus.instr_pc, pc);
          checkOutput("instr_data", bus.instr_data, memWord(pc));
        end
        if (instrCount == 0) firstInstrPc = bus.instr_pc;
        instrCount++;
      end
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = memReady;
    bus.instr_ready    = decReady;
    pendQ.delete();
    expInstrQ.delete();
    lastDue    = 0;
    cycleNum   = 0;
    reqCount   = 0;
    instrCount = 0;
    #1;
    checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_instr_data", bus.instr_data, 32'd0);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'd0);
    checkOutput("rst_misalign", 32'(bus.fetch_misalign), 32'd0);
    checkOutput("rst_req_addr", bus.imem_req_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("boot_no_req", 32'(bus.imem_req_valid), 32'd0);
    expNextReq = RESET_PC;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst_n    = 1'b0;
    memReady = 1'b1;
    decReady = 1'b1;
    latency  = 1;

    // Streaming at latency 1 with decode always ready.
    resetDut();
    applyStimulus(1'b0, '0);
    checkOutput("t1_first_req", firstReqAddr, RESET_PC);
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, '0);
    checkOutput("t1_progress", 32'(instrCount >= 10), 32'd1);
    checkOutput("t1_first_instr", firstInstrPc, RESET_PC);

    // Decode stalled: two words fill the buffer and requests stop.
    decReady = 1'b0;
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0);
      if (i >= 3) begin
        checkOutput("t2_held_pc", bus.instr_pc, 32'h0);
        checkOutput("t2_held_data", bus.instr_data, memWord(32'h0));
      end
    end
    heldData = bus.instr_data;
    checkOutput("t2_req_count", 32'(reqCount), 32'd2);
    checkOutput("t2_req_stalled", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("t2_instr_valid", 32'(bus.instr_valid), 32'd1);
    decReady = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0);
    checkOutput("t2_resumed", 32'(instrCount >= 6), 32'd1);

    // Redirect with two fetches in flight at latency 3.
    latency = 3;
    resetDut();
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkOutput("t3_inflight", 32'(reqCount), 32'd2);
    reqCount   = 0;
    instrCount = 0;
    applyStimulus(1'b1, 32'h100);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, '0);
      checkOutput("t3_flush_no_req", 32'(bus.imem_req_valid), 32'd0);
      checkOutput("t3_flush_no_instr", 32'(bus.instr_valid), 32'd0);
    end
    applyStimulus(1'b0, '0);
    checkOutput("t3_resume_req", 32'(bus.imem_req_valid), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0);
    checkOutput("t3_first_req", firstReqAddr, 32'h100);
    checkOutput("t3_first_instr", firstInstrPc, 32'h100);

    // Redirect coinciding with a response while memory is ready.
    latency = 1;
    resetDut();
    applyStimulus(1'b0, '0);
    reqCount   = 0;
    instrCount = 0;
    applyStimulus(1'b1, 32'h40);
    applyStimulus(1'b0, '0);
    checkOutput("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("t4_req_addr", bus.imem_req_addr, 32'h40);
    checkOutput("t4_dropped", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0);
    checkOutput("t4_first_instr", firstInstrPc, 32'h40);

    // Misaligned redirect target.
    reqCount   = 0;
    instrCount = 0;
    applyStimulus(1'b1, 32'h203);
    applyStimulus(1'b0, '0);
    checkOutput("t5_misalign_set", 32'(bus.fetch_misalign), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0);
    checkOutput("t5_first_req", firstReqAddr, 32'h200);
    applyStimulus(1'b1, 32'h300);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0);
    checkOutput("t5_misalign_sticky", 32'(bus.fetch_misalign), 32'd1);

    // Address wrap at the top of memory, then an asynchronous reset mid-burst.
    reqCount   = 0;
    instrCount = 0;
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0);
    checkOutput("t6_first_req", firstReqAddr, 32'hFFFF_FFFC);
    checkOutput("t6_wrapped", 32'(reqCount >= 2), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("t6_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("t6_rst_instr_data", bus.instr_data, 32'd0);
    checkOutput("t6_rst_instr_pc", bus.instr_pc, 32'd0);
    checkOutput("t6_rst_misalign", 32'(bus.fetch_misalign), 32'd0);
    checkOutput("t6_rst_req_addr", bus.imem_req_addr, RESET_PC);
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0);
    checkOutput("t6_restart_req", firstReqAddr, RESET_PC);
    checkOutput("t6_restart_instr", firstInstrPc, RESET_PC);

    // Random back-pressure on both sides with occasional redirects.
    latency = 2;
    resetDut();
    for (int i = 0; i < 300; i++) begin
      memReady = ($urandom_range(0, 3) != 0);
      decReady = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) applyStimulus(1'b1, $urandom);
      else                            applyStimulus(1'b0, '0);
    end
    memReady = 1'b1;
    decReady = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0);
    checkOutput("rand_progress", 32'(instrCount >= 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
